// File: rtl/nios2_touch_i2c_master_if.sv
// Avalon-MM register port of the touch-panel I2C master.
interface nios2_touch_i2c_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_touch_i2c_master.sv
// Byte-command I2C master for the touch-panel bus.
// Open-drain SCL/SDA sequenced in quarter-bit phases.
module nios2_touch_i2c_master #(
  parameter logic [15:0] DEFAULT_CLKDIV = 16'd124,
  parameter bit          STRETCH_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  nios2_touch_i2c_master_if.slave bus,
  output logic scl_oe,
  output logic sda_oe,
  input  logic scl_in,
  input  logic sda_in,
  output logic irq
);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_BIT, S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] div_q, div_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        sto_q, sto_d;
  logic        txnack_q, txnack_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;

  logic        wr_en;
  logic        stall;
  logic        tick;
  logic [5:0]  cmd;
  logic        unused_wd;

  assign wr_en = bus.chipselect & ~bus.write_n & ~busy_q;
  assign cmd   = bus.writedata[5:0];
  assign unused_wd = ^bus.writedata[31:16];

  // Slave holding SCL low freezes the quarter counter.
  assign stall = STRETCH_EN && state_q == S_BIT &&
                 (ph_q == 2'd1 || ph_q == 2'd2) && !scl_in;
  assign tick  = busy_q && !stall && cnt_q == div_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_d   = done_q;
    nack_d   = nack_q;
    irq_en_d = irq_en_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sh_d     = sh_q;
    div_d    = div_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    sto_d    = sto_q;
    txnack_d = txnack_q;
    scl_d    = scl_q;
    sda_d    = sda_q;

    if (wr_en) begin
      unique case (bus.address)
        2'd0: begin
          irq_en_d = cmd[5];
          done_d   = 1'b0;
          nack_d   = 1'b0;
          if (|cmd[3:0]) begin
            busy_d   = 1'b1;
            wr_d     = cmd[1];
            rd_d     = cmd[2] & ~cmd[1];
            sto_d    = cmd[3];
            txnack_d = cmd[4];
            cnt_d    = '0;
            ph_d     = '0;
            bit_d    = '0;
            if (cmd[0])
              state_d = S_START;
            else if (cmd[1] | cmd[2])
              state_d = S_BIT;
            else
              state_d = S_STOP;
          end
        end
        2'd1: tx_d  = bus.writedata[7:0];
        2'd2: ;
        2'd3: div_d = bus.writedata[15:0];
      endcase
    end else if (busy_q) begin
      if (!stall)
        cnt_d = tick ? '0 : cnt_q + 16'd1;
      if (tick) begin
        ph_d = ph_q + 2'd1;
        if (state_q == S_BIT && ph_q == 2'd2) begin
          if (wr_q) begin
            if (bit_q == 4'd8)
              nack_d = sda_in;
          end else if (bit_q != 4'd8) begin
            sh_d = {sh_q[6:0], sda_in};
            if (bit_q == 4'd7)
              rx_d = {sh_q[6:0], sda_in};
          end
        end
        if (ph_q == 2'd3) begin
          unique case (state_q)
            S_START: begin
              bit_d = '0;
              if (wr_q | rd_q)
                state_d = S_BIT;
              else
                state_d = sto_q ? S_STOP : S_IDLE;
            end
            S_BIT: begin
              if (bit_q != 4'd8)
                bit_d = bit_q + 4'd1;
              else
                state_d = sto_q ? S_STOP : S_IDLE;
            end
            S_STOP: state_d = S_IDLE;
            default: ;
          endcase
          if (state_d == S_IDLE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
    end

    // Line drive follows the phase being entered; idle holds.
    unique case (state_d)
      S_START: begin
        scl_d = ph_d[1];
        sda_d = ph_d != 2'd0;
      end
      S_BIT: begin
        scl_d = ph_d == 2'd0 || ph_d == 2'd3;
        if (bit_d == 4'd8)
          sda_d = rd_d & ~txnack_d;
        else
          sda_d = wr_d & ~tx_q[~bit_d[2:0]];
      end
      S_STOP: begin
        scl_d = ph_d == 2'd0;
        sda_d = ~ph_d[1];
      end
      S_IDLE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      irq_en_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      sh_q     <= '0;
      div_q    <= DEFAULT_CLKDIV;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      sto_q    <= 1'b0;
      txnack_q <= 1'b0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      irq_en_q <= irq_en_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sh_q     <= sh_d;
      div_q    <= div_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      sto_q    <= sto_d;
      txnack_q <= txnack_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata[2:0]  = {nack_q, done_q, busy_q};
      2'd1: bus.readdata[7:0]  = tx_q;
      2'd2: bus.readdata[7:0]  = rx_q;
      2'd3: bus.readdata[15:0] = div_q;
    endcase
  end

  assign scl_oe = scl_q;
  assign sda_oe = sda_q;
  assign irq    = done_q & irq_en_q;

endmodule

// File: tb/tb_nios2_touch_i2c_master.sv
// Bench for the touch-panel I2C master: bus slave model plus
// a scoreboard of expected per-command results.
`timescale 1ns/1ps
module tb_nios2_touch_i2c_master;

  localparam int M_NONE = 0;
  localparam int M_ACK  = 1;
  localparam int M_RD   = 2;

  typedef struct {
    logic [31:0] status;
    int          cycles;
    logic [7:0]  rx;
    logic [7:0]  wbyte;
    bit          chk_rx;
    bit          chk_w;
    bit          chk_ack;
    bit          ack_oe;
    bit          scl_end;
    bit          irq;
    int          starts;
    int          stops;
  } exp_t;

  logic clk;
  logic reset;
  logic scl_oe, sda_oe, scl_in, sda_in, irq;

  nios2_touch_i2c_master_if bus ();

  nios2_touch_i2c_master dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .irq    (irq)
  );

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];

  int         slave_mode = M_NONE;
  logic [7:0] rbyte = 8'h00;
  int         str_len = 0;
  int         clr_req = 0;
  int         div = 124;
  logic [7:0] txv = 8'h00;

  int         clr_seen = 0;
  int         fall_cnt = 0;
  logic [7:0] cap = 8'h00;
  int         n_start = 0;
  int         n_stop = 0;
  logic       ack_oe = 1'b0;
  logic       hold = 1'b0;
  int         hold_left = 0;
  bit         trig_done = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       ms, md;
  logic       s_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_low = 1'b0;
    if (slave_mode == M_ACK && fall_cnt == 9)
      s_low = 1'b1;
    if (slave_mode == M_RD && fall_cnt >= 1 && fall_cnt <= 8)
      s_low = !rbyte[3'(8 - fall_cnt)];
  end

  assign sda_in = ~sda_oe & ~s_low;
  assign scl_in = ~scl_oe & ~hold;

  always @(negedge clk) begin
    ms = ~scl_oe;
    md = sda_in;
    if (clr_req != clr_seen) begin
      clr_seen  = clr_req;
      fall_cnt  = 0;
      cap       = 8'h00;
      n_start   = 0;
      n_stop    = 0;
      ack_oe    = 1'b0;
      trig_done = 1'b0;
    end
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) hold = 1'b0;
    end else if (str_len > 0 && !trig_done && !prev_scl && ms &&
                 fall_cnt == 4) begin
      hold      = 1'b1;
      hold_left = str_len;
      trig_done = 1'b1;
    end
    if (prev_scl && !ms) fall_cnt++;
    if (!prev_scl && ms) begin
      if (fall_cnt >= 1 && fall_cnt <= 8) cap = {cap[6:0], md};
      if (fall_cnt == 9) ack_oe = sda_oe;
    end
    if (prev_scl && ms && prev_sda && !md) n_start++;
    if (prev_scl && ms && !prev_sda && md) n_stop++;
    prev_scl = ms;
    prev_sda = md;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
  endtask

  task automatic idle_bus();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d,
                        input bit nowait);
    if (!nowait) @(negedge clk);
    drive(a, d);
    @(negedge clk);
    idle_bus();
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    #1;
    v = bus.readdata;
  endtask

  task automatic run(input logic [5:0] cmd, input int str,
                     input bit nowait, input bit meddle);
    exp_t e;
    exp_t g;
    int c;
    logic [31:0] v;
    bit xfer, rdo;
    xfer = cmd[1] | cmd[2];
    rdo  = cmd[2] & ~cmd[1];
    e.cycles  = ((cmd[0] ? 4 : 0) + (xfer ? 36 : 0) +
                 (cmd[3] ? 4 : 0)) * (div + 1) + str;
    e.status  = {29'd0, cmd[1] && slave_mode == M_NONE, 1'b1, 1'b0};
    e.rx      = rbyte;
    e.wbyte   = txv;
    e.chk_rx  = rdo;
    e.chk_w   = cmd[1];
    e.chk_ack = xfer;
    e.ack_oe  = rdo ? !cmd[4] : 1'b0;
    e.scl_end = !cmd[3];
    e.irq     = cmd[5];
    e.starts  = int'(cmd[0]);
    e.stops   = int'(cmd[3]);
    sbq.push_back(e);
    clr_req++;
    bus_wr(2'd0, {26'd0, cmd}, nowait);
    c = 0;
    while (bus.readdata[0] && c < 20000) begin
      c++;
      if (meddle) begin
        if (c == 10) drive(2'd1, 32'h11);
        if (c == 11) drive(2'd3, 32'h7);
        if (c == 12) drive(2'd0, 32'h04);
        if (c == e.cycles) drive(2'd0, 32'h04);
      end
      @(negedge clk);
      idle_bus();
      #1;
    end
    g = sbq.pop_front();
    chk("status", bus.readdata, g.status);
    chk("cycles", c, g.cycles);
    chk("scl_end", {31'd0, scl_oe}, {31'd0, g.scl_end});
    chk("irq", {31'd0, irq}, {31'd0, g.irq});
    chk("starts", n_start, g.starts);
    chk("stops", n_stop, g.stops);
    if (g.chk_w) chk("wbyte", {24'd0, cap}, {24'd0, g.wbyte});
    if (g.chk_ack) chk("ack_oe", {31'd0, ack_oe}, {31'd0, g.ack_oe});
    if (g.chk_rx) begin
      rd(2'd2, v);
      chk("rxdata", v, {24'd0, g.rx});
      bus.address = 2'd0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int w;
    reset = 1'b1;
    bus.writedata = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_scl", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda", {31'd0, sda_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); chk("rst_status", v, 32'd0);
    rd(2'd1, v); chk("rst_tx", v, 32'd0);
    rd(2'd2, v); chk("rst_rx", v, 32'd0);
    rd(2'd3, v); chk("rst_div", v, 32'd124);

    bus_wr(2'd3, 32'd3, 1'b0);   div = 3;
    bus_wr(2'd1, 32'hA5, 1'b0);  txv = 8'hA5;

    slave_mode = M_ACK;
    run(6'h0B, 0, 1'b0, 1'b0);
    chk("t1_sda_rel", {31'd0, sda_oe}, 32'd0);

    slave_mode = M_RD; rbyte = 8'h3C;
    run(6'h04, 0, 1'b0, 1'b0);

    slave_mode = M_NONE;
    run(6'h0B, 0, 1'b0, 1'b0);

    slave_mode = M_ACK; str_len = 50;
    run(6'h0B, 50, 1'b0, 1'b0);
    str_len = 0;

    run(6'h0B, 0, 1'b0, 1'b1);
    slave_mode = M_NONE;
    run(6'h28, 0, 1'b1, 1'b0);
    rd(2'd1, v); chk("t5_tx", v, 32'hA5);
    rd(2'd3, v); chk("t5_div", v, 32'd3);
    bus.address = 2'd0;

    slave_mode = M_ACK;
    clr_req++;
    bus_wr(2'd0, 32'h0B, 1'b0);
    w = 0;
    while (fall_cnt < 5 && w < 2000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("t6_reach", {31'd0, fall_cnt >= 5}, 32'd1);
    slave_mode = M_NONE;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_scl", {31'd0, scl_oe}, 32'd0);
    chk("t6_sda", {31'd0, sda_oe}, 32'd0);
    rd(2'd0, v); chk("t6_status", v, 32'd0);
    rd(2'd3, v); chk("t6_div", v, 32'd124);
    bus.address = 2'd0;
    reset = 1'b0;
    div = 124; txv = 8'h00;
    run(6'h21, 0, 1'b0, 1'b0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
